// File: rtl/mulcnt_host_pkg.sv
// Shared constants, state encodings and small helpers for the mulcnt_host
// bus initiator and its single-access bus engine.
package mulcnt_host_pkg;

  // Default register map of the multiply/popcount peripheral.
  localparam logic [15:0] DEF_ADDR_A1   = 16'h0380;
  localparam logic [15:0] DEF_ADDR_A2   = 16'h0388;
  localparam logic [15:0] DEF_ADDR_W    = 16'h0390;
  localparam logic [15:0] DEF_ADDR_L    = 16'h0398;
  localparam logic [15:0] DEF_ADDR_CTRL = 16'h03A0;

  // Status bits [1:0] reported by the peripheral once the job has finished.
  localparam logic [1:0] STAT_DONE = 2'b11;

  // Job sequencer states, one per bus access plus the poll gap and done.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WR_A1   = 4'd1,
    ST_WR_A2   = 4'd2,
    ST_WR_CTRL = 4'd3,
    ST_POLL    = 4'd4,
    ST_GAP     = 4'd5,
    ST_RD_W    = 4'd6,
    ST_RD_L    = 4'd7,
    ST_DONE    = 4'd8
  } state_t;

  // Phases of a single strobe-bus access; PH_IDLE is the parked bus.
  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_STROBE = 2'd2,
    PH_HOLD   = 2'd3
  } phase_t;

  // True when a status word reports job completion.
  function automatic logic status_done(input logic [31:0] stat);
    return (stat[1:0] == STAT_DONE);
  endfunction

  // Zero-extend a 24-bit operand to the 32-bit bus width.
  function automatic logic [31:0] zext24(input logic [23:0] v);
    return {8'h00, v};
  endfunction

endpackage

// File: rtl/mulcnt_host_sbus_access.sv
// Single-access engine for the saddress/srd/swr strobe bus. One request
// produces SETUP (1 cycle), STROBE (STROBE_CYCLES cycles) and HOLD (1 cycle).
// A new request may be presented during HOLD so accesses run back to back.
module sbus_access
  import mulcnt_host_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req,
  input  logic        rnw,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_wr,
  input  logic [31:0] sdata_rd
);

  localparam logic [7:0] STB_LAST = 8'(STROBE_CYCLES - 1);

  phase_t     phase_r;
  logic       rnw_r;
  logic [7:0] stb_cnt_r;

  // ack marks the HOLD cycle; rdata already holds the sampled read word.
  assign ack = (phase_r == PH_HOLD);

  // Access phase sequencing with registered bus pins.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      phase_r   <= PH_IDLE;
      rnw_r     <= 1'b0;
      stb_cnt_r <= 8'h00;
      rdata     <= 32'h0000_0000;
      saddress  <= 16'h0000;
      srd       <= 1'b0;
      swr       <= 1'b0;
      sdata_wr  <= 32'h0000_0000;
    end else begin
      case (phase_r)
        PH_IDLE, PH_HOLD: begin
          if (req) begin
            phase_r  <= PH_SETUP;
            rnw_r    <= rnw;
            saddress <= addr;
            sdata_wr <= rnw ? 32'h0000_0000 : wdata;
          end else begin
            phase_r  <= PH_IDLE;
            rnw_r    <= 1'b0;
            saddress <= 16'h0000;
            sdata_wr <= 32'h0000_0000;
          end
        end
        PH_SETUP: begin
          phase_r   <= PH_STROBE;
          stb_cnt_r <= 8'h00;
          srd       <= rnw_r;
          swr       <= ~rnw_r;
        end
        PH_STROBE: begin
          if (stb_cnt_r == STB_LAST) begin
            phase_r <= PH_HOLD;
            srd     <= 1'b0;
            swr     <= 1'b0;
            if (rnw_r) begin
              rdata <= sdata_rd;
            end
          end else begin
            stb_cnt_r <= stb_cnt_r + 8'h01;
          end
        end
        default: begin
          phase_r  <= PH_IDLE;
          srd      <= 1'b0;
          swr      <= 1'b0;
          saddress <= 16'h0000;
          sdata_wr <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: rtl/mulcnt_host.sv
// Bus initiator for the multiply/popcount peripheral: writes both operands
// and the control word, polls status, reads product and ones-count, and
// reports the outcome with a one-cycle done pulse.
module mulcnt_host
  import mulcnt_host_pkg::*;
#(
  parameter logic [15:0] ADDR_A1       = DEF_ADDR_A1,
  parameter logic [15:0] ADDR_A2       = DEF_ADDR_A2,
  parameter logic [15:0] ADDR_W        = DEF_ADDR_W,
  parameter logic [15:0] ADDR_L        = DEF_ADDR_L,
  parameter logic [15:0] ADDR_CTRL     = DEF_ADDR_CTRL,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned POLL_GAP      = 4,
  parameter int unsigned POLL_LIMIT    = 255
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic [23:0] arg_a,
  input  logic [23:0] arg_b,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic [31:0] result_w,
  output logic [23:0] result_l,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_wr,
  input  logic [31:0] sdata_rd
);

  localparam logic [15:0] LIMIT_C  = 16'(POLL_LIMIT);
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  state_t      state_r;
  state_t      state_nxt;
  logic        req;
  logic        rnw;
  logic [15:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        ack;
  logic [31:0] rdata;
  logic [23:0] arg_b_r;
  logic [15:0] poll_cnt_r;
  logic [15:0] gap_cnt_r;
  logic [31:0] w_tmp_r;
  logic        poll_last;

  // The poll now completing is the last one allowed.
  assign poll_last = ((poll_cnt_r + 16'h0001) >= LIMIT_C);

  sbus_access #(
    .STROBE_CYCLES (STROBE_CYCLES)
  ) u_access (
    .clk      (clk),
    .n_reset  (n_reset),
    .req      (req),
    .rnw      (rnw),
    .addr     (acc_addr),
    .wdata    (acc_wdata),
    .ack      (ack),
    .rdata    (rdata),
    .saddress (saddress),
    .srd      (srd),
    .swr      (swr),
    .sdata_wr (sdata_wr),
    .sdata_rd (sdata_rd)
  );

  // Job state register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next state and next access request; each request is issued on the
  // previous access's HOLD cycle so accesses abut without idle cycles.
  always_comb begin
    state_nxt = state_r;
    req       = 1'b0;
    rnw       = 1'b0;
    acc_addr  = 16'h0000;
    acc_wdata = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          req       = 1'b1;
          acc_addr  = ADDR_A1;
          acc_wdata = zext24(arg_a);
          state_nxt = ST_WR_A1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WR_A1: begin
        if (ack) begin
          req       = 1'b1;
          acc_addr  = ADDR_A2;
          acc_wdata = zext24(arg_b_r);
          state_nxt = ST_WR_A2;
        end else begin
          state_nxt = ST_WR_A1;
        end
      end
      ST_WR_A2: begin
        if (ack) begin
          req       = 1'b1;
          acc_addr  = ADDR_CTRL;
          state_nxt = ST_WR_CTRL;
        end else begin
          state_nxt = ST_WR_A2;
        end
      end
      ST_WR_CTRL: begin
        if (ack) begin
          req       = 1'b1;
          rnw       = 1'b1;
          acc_addr  = ADDR_CTRL;
          state_nxt = ST_POLL;
        end else begin
          state_nxt = ST_WR_CTRL;
        end
      end
      ST_POLL: begin
        if (ack) begin
          if (status_done(rdata)) begin
            req       = 1'b1;
            rnw       = 1'b1;
            acc_addr  = ADDR_W;
            state_nxt = ST_RD_W;
          end else if (poll_last) begin
            state_nxt = ST_DONE;
          end else if (POLL_GAP == 32'd0) begin
            req       = 1'b1;
            rnw       = 1'b1;
            acc_addr  = ADDR_CTRL;
            state_nxt = ST_POLL;
          end else begin
            state_nxt = ST_GAP;
          end
        end else begin
          state_nxt = ST_POLL;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          req       = 1'b1;
          rnw       = 1'b1;
          acc_addr  = ADDR_CTRL;
          state_nxt = ST_POLL;
        end else begin
          state_nxt = ST_GAP;
        end
      end
      ST_RD_W: begin
        if (ack) begin
          req       = 1'b1;
          rnw       = 1'b1;
          acc_addr  = ADDR_L;
          state_nxt = ST_RD_L;
        end else begin
          state_nxt = ST_RD_W;
        end
      end
      ST_RD_L: begin
        if (ack) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_RD_L;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand B capture, poll/gap counters and the product holding register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      arg_b_r    <= 24'h00_0000;
      poll_cnt_r <= 16'h0000;
      gap_cnt_r  <= 16'h0000;
      w_tmp_r    <= 32'h0000_0000;
    end else begin
      if ((state_r == ST_IDLE) && start) begin
        arg_b_r    <= arg_b;
        poll_cnt_r <= 16'h0000;
      end else if ((state_r == ST_POLL) && ack) begin
        poll_cnt_r <= poll_cnt_r + 16'h0001;
      end
      if (state_r == ST_GAP) begin
        gap_cnt_r <= gap_cnt_r + 16'h0001;
      end else begin
        gap_cnt_r <= 16'h0000;
      end
      if ((state_r == ST_RD_W) && ack) begin
        w_tmp_r <= rdata;
      end
    end
  end

  // Registered status and results; results change only on entry to DONE.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      result_w    <= 32'h0000_0000;
      result_l    <= 24'h00_0000;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      done <= (state_nxt == ST_DONE);
      if ((state_r == ST_RD_L) && (state_nxt == ST_DONE)) begin
        result_w    <= w_tmp_r;
        result_l    <= rdata[23:0];
        err_timeout <= 1'b0;
      end else if ((state_r == ST_POLL) && (state_nxt == ST_DONE)) begin
        result_w    <= 32'h0000_0000;
        result_l    <= 24'h00_0000;
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mulcnt_host.sv
// Self-checking bench for mulcnt_host: a peripheral responder model, a bus
// monitor that logs every access and checks strobe shape, and a job runner
// comparing results, bus traffic and latency against expectations.
module tb_mulcnt_host;

  localparam int SC   = 2;
  localparam int GAP  = 4;
  localparam int ACC  = SC + 2;
  localparam int LIM0 = 255;
  localparam int LIM1 = 3;
  localparam logic [31:0] STAT_OK   = 32'hA5A5_A5A7;
  localparam logic [31:0] STAT_BUSY = 32'hA5A5_A5A5;

  typedef struct packed {
    logic        rnw;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] t;
  } txn_t;

  typedef struct packed {
    logic [23:0] a;
    logic [23:0] b;
    logic [7:0]  fails;
    logic [31:0] exp_w;
    logic [23:0] exp_l;
  } vec_t;

  logic        clk;
  logic        n_reset;
  logic        start    [2];
  logic [23:0] arg_a    [2];
  logic [23:0] arg_b    [2];
  logic        busy     [2];
  logic        done     [2];
  logic        err_to   [2];
  logic [31:0] result_w [2];
  logic [23:0] result_l [2];
  logic [15:0] saddress [2];
  logic        srd      [2];
  logic        swr      [2];
  logic [31:0] sdata_wr [2];
  logic [31:0] sdata_rd [2];

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          fail_cnt  [2];
  int          poll_seen [2];
  logic [23:0] a_seen    [2];
  logic [23:0] b_seen    [2];
  txn_t        log_mem   [2][64];
  int          log_n     [2];

  logic        prev_stb  [2];
  logic [15:0] prev_addr [2];
  int          stb_len   [2];
  logic [15:0] stb_addr  [2];
  logic [31:0] stb_data  [2];
  logic        stb_rnw   [2];
  int          stb_t     [2];
  logic        excl_bad  [2];
  logic        stab_bad  [2];
  logic        cur_stb;

  mulcnt_host #(.POLL_LIMIT(LIM0)) dut0 (
    .clk(clk), .n_reset(n_reset), .start(start[0]), .arg_a(arg_a[0]), .arg_b(arg_b[0]),
    .busy(busy[0]), .done(done[0]), .err_timeout(err_to[0]), .result_w(result_w[0]),
    .result_l(result_l[0]), .saddress(saddress[0]), .srd(srd[0]), .swr(swr[0]),
    .sdata_wr(sdata_wr[0]), .sdata_rd(sdata_rd[0])
  );

  mulcnt_host #(.POLL_LIMIT(LIM1)) dut1 (
    .clk(clk), .n_reset(n_reset), .start(start[1]), .arg_a(arg_a[1]), .arg_b(arg_b[1]),
    .busy(busy[1]), .done(done[1]), .err_timeout(err_to[1]), .result_w(result_w[1]),
    .result_l(result_l[1]), .saddress(saddress[1]), .srd(srd[1]), .swr(swr[1]),
    .sdata_wr(sdata_wr[1]), .sdata_rd(sdata_rd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral semantics: product is the low 32 bits of a*b, L counts its ones.
  function automatic logic [31:0] model_w(input logic [23:0] a, input logic [23:0] b);
    logic [47:0] p;
    p = 48'(a) * 48'(b);
    return p[31:0];
  endfunction

  function automatic logic [23:0] model_l(input logic [31:0] w);
    return 24'($countones(w));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder: status fails for the first fail_cnt polls, then reports done.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sdata_rd[i] = 32'hDEAD_BEEF;
      case (saddress[i])
        16'h03A0: sdata_rd[i] = (poll_seen[i] >= fail_cnt[i]) ? STAT_OK : STAT_BUSY;
        16'h0390: sdata_rd[i] = model_w(a_seen[i], b_seen[i]);
        16'h0398: sdata_rd[i] = {8'h00, model_l(model_w(a_seen[i], b_seen[i]))};
        default:  sdata_rd[i] = 32'hDEAD_BEEF;
      endcase
    end
  end

  // Bus monitor: logs completed accesses and checks strobe shape.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!n_reset) begin
        prev_stb[i]  = 1'b0;
        prev_addr[i] = 16'h0000;
      end else begin
        cur_stb = srd[i] | swr[i];
        if (cur_stb && !prev_stb[i]) begin
          stb_len[i]  = 1;
          stb_addr[i] = saddress[i];
          stb_data[i] = sdata_wr[i];
          stb_rnw[i]  = srd[i];
          stb_t[i]    = cyc;
          excl_bad[i] = srd[i] & swr[i];
          stab_bad[i] = 1'b0;
          chk("setup_addr", {48'h0, saddress[i]}, {48'h0, prev_addr[i]});
        end else if (cur_stb) begin
          stb_len[i] = stb_len[i] + 1;
          if (srd[i] && swr[i]) excl_bad[i] = 1'b1;
          if (saddress[i] != stb_addr[i] || sdata_wr[i] != stb_data[i] || srd[i] != stb_rnw[i])
            stab_bad[i] = 1'b1;
        end else if (prev_stb[i]) begin
          chk("strobe_len", 64'(stb_len[i]), 64'(SC));
          chk("strobe_excl", {63'h0, excl_bad[i]}, 64'h0);
          chk("addr_stable", {63'h0, stab_bad[i] | (saddress[i] != stb_addr[i]) |
                              (sdata_wr[i] != stb_data[i])}, 64'h0);
          if (log_n[i] < 64) begin
            log_mem[i][log_n[i]] = '{rnw: stb_rnw[i], addr: stb_addr[i],
                                     data: (stb_rnw[i] ? 32'h0 : stb_data[i]), t: 32'(stb_t[i])};
            log_n[i] = log_n[i] + 1;
          end
          if (stb_rnw[i] && stb_addr[i] == 16'h03A0) poll_seen[i] = poll_seen[i] + 1;
          if (!stb_rnw[i] && stb_addr[i] == 16'h0380) a_seen[i] = stb_data[i][23:0];
          if (!stb_rnw[i] && stb_addr[i] == 16'h0388) b_seen[i] = stb_data[i][23:0];
        end
        prev_stb[i]  = cur_stb;
        prev_addr[i] = saddress[i];
      end
    end
  end

  // One job on instance i; expected bus traffic is rebuilt from the job shape.
  task automatic run_job(input int i, input logic [23:0] a, input logic [23:0] b,
                         input int fails, input logic [31:0] exp_w, input logic [23:0] exp_l,
                         input bit exp_to, input bit repulse);
    int c0, lat, np, nexp, nlog, dt, edt;
    bit got;
    logic [15:0] e_addr;
    logic [31:0] e_data;
    logic e_rnw;
    fail_cnt[i]  = fails;
    poll_seen[i] = 0;
    log_n[i]     = 0;
    @(negedge clk);
    arg_a[i] = a;
    arg_b[i] = b;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    c0 = cyc;
    chk("busy_accept", {63'h0, busy[i]}, 64'h1);
    arg_a[i] = 24'($urandom);
    arg_b[i] = 24'($urandom);
    got = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (done[i]) begin
        got = 1'b1;
        break;
      end
      start[i] = (repulse && (n == 8 || n == 9)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start[i] = 1'b0;
    chk("done_seen", {63'h0, got}, 64'h1);
    np  = exp_to ? ((i == 0) ? LIM0 : LIM1) : fails + 1;
    lat = cyc - c0 + 1;
    chk("latency", 64'(lat), 64'((exp_to ? 3 : 5) * ACC + np * ACC + (np - 1) * GAP + 1));
    chk("err_timeout", {63'h0, err_to[i]}, {63'h0, exp_to});
    chk("result_w", {32'h0, result_w[i]}, {32'h0, exp_w});
    chk("result_l", {40'h0, result_l[i]}, {40'h0, exp_l});
    chk("busy_in_done", {63'h0, busy[i]}, 64'h1);
    if (repulse) start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    chk("done_pulse", {63'h0, done[i]}, 64'h0);
    chk("busy_after", {63'h0, busy[i]}, 64'h0);
    if (repulse) begin
      repeat (30) @(negedge clk);
      chk("no_second_job", {63'h0, busy[i]}, 64'h0);
    end
    nexp = 3 + np + (exp_to ? 0 : 2);
    nlog = log_n[i];
    chk("txn_count", 64'(nlog), 64'(nexp));
    for (int k = 0; k < nexp && k < nlog; k++) begin
      e_rnw = 1'b1; e_data = 32'h0; e_addr = 16'h03A0;
      if (k == 0)          begin e_rnw = 1'b0; e_addr = 16'h0380; e_data = {8'h0, a}; end
      else if (k == 1)     begin e_rnw = 1'b0; e_addr = 16'h0388; e_data = {8'h0, b}; end
      else if (k == 2)     begin e_rnw = 1'b0; e_addr = 16'h03A0; end
      else if (k < 3 + np) begin e_addr = 16'h03A0; end
      else if (k == 3 + np) begin e_addr = 16'h0390; end
      else                 begin e_addr = 16'h0398; end
      chk($sformatf("txn%0d", k), {15'h0, log_mem[i][k].rnw, log_mem[i][k].addr, log_mem[i][k].data},
          {15'h0, e_rnw, e_addr, e_data});
      if (k >= 1) begin
        dt  = int'(log_mem[i][k].t) - int'(log_mem[i][k-1].t);
        edt = (k >= 4 && k < 3 + np) ? ACC + GAP : ACC;
        chk($sformatf("spacing%0d", k), 64'(dt), 64'(edt));
      end
    end
  endtask

  vec_t tbl [4];

  initial begin
    logic [23:0] ra, rb;
    int rf;
    bit got;
    n_reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; arg_a[i] = 24'h0; arg_b[i] = 24'h0;
      fail_cnt[i] = 0; poll_seen[i] = 0; log_n[i] = 0;
      a_seen[i] = 24'h0; b_seen[i] = 24'h0;
    end
    tbl[0] = '{a: 24'd3,       b: 24'd5,       fails: 8'd0, exp_w: 32'h0000_000F, exp_l: 24'd4};
    tbl[1] = '{a: 24'hFFFFFF,  b: 24'hFFFFFF,  fails: 8'd3, exp_w: 32'hFE00_0001, exp_l: 24'd8};
    tbl[2] = '{a: 24'h000000,  b: 24'h123456,  fails: 8'd1, exp_w: 32'h0000_0000, exp_l: 24'd0};
    tbl[3] = '{a: 24'h001000,  b: 24'h001000,  fails: 8'd2, exp_w: 32'h0100_0000, exp_l: 24'd1};

    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", {63'h0, busy[i]}, 64'h0);
      chk("rst_done", {63'h0, done[i]}, 64'h0);
      chk("rst_err", {63'h0, err_to[i]}, 64'h0);
      chk("rst_results", {8'h0, result_w[i], result_l[i]}, 64'h0);
      chk("rst_bus", {14'h0, saddress[i], srd[i], swr[i], sdata_wr[i]}, 64'h0);
    end
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++)
      run_job(0, tbl[v].a, tbl[v].b, int'(tbl[v].fails), tbl[v].exp_w, tbl[v].exp_l, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      rf = int'($urandom_range(0, 4));
      run_job(0, ra, rb, rf, model_w(ra, rb), model_l(model_w(ra, rb)), 1'b0, 1'b0);
    end

    run_job(0, 24'h00ABCD, 24'h000777, 1, model_w(24'h00ABCD, 24'h000777),
            model_l(model_w(24'h00ABCD, 24'h000777)), 1'b0, 1'b1);

    run_job(1, 24'd7, 24'd9, 0, 32'd63, 24'd6, 1'b0, 1'b0);
    run_job(1, 24'd11, 24'd13, 1000, 32'h0, 24'h0, 1'b1, 1'b0);

    // Reset in the middle of the WR_A2 strobe.
    fail_cnt[0] = 0;
    @(negedge clk);
    arg_a[0] = 24'h000021; arg_b[0] = 24'h000042; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (swr[0] && saddress[0] == 16'h0388) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_wr_a2", {63'h0, got}, 64'h1);
    #2 n_reset = 1'b0;
    #1;
    chk("arst_swr", {63'h0, swr[0]}, 64'h0);
    chk("arst_busy", {63'h0, busy[0]}, 64'h0);
    chk("arst_bus", {15'h0, saddress[0], srd[0], sdata_wr[0]}, 64'h0);
    chk("arst_results", {7'h0, done[0], result_w[0], result_l[0]}, 64'h0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    run_job(0, 24'h000123, 24'h000456, 2, model_w(24'h000123, 24'h000456),
            model_l(model_w(24'h000123, 24'h000456)), 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mulcnt_host.md
# mulcnt_host

Bus initiator that drives the multiply/popcount GPIO emulator peripheral from the far side of its `saddress`/`srd`/`swr` strobe bus. On a single `start` pulse it writes both 24-bit operands and the control word. It then polls the status register until the job reports done, reads back the 32-bit product and the ones-count, and presents them with a one-cycle `done` pulse. It sits between a local controller (or testbench sequencer) and the emulator's slave port, replacing hand-written bus transactions.

## Interface
- `ADDR_A1`, default 16'h0380, operand A write address
- `ADDR_A2`, default 16'h0388, operand B write address
- `ADDR_W`, default 16'h0390, product read address
- `ADDR_L`, default 16'h0398, ones-count read address
- `ADDR_CTRL`, default 16'h03A0, control write / status read address
- `STROBE_CYCLES`, default 2, cycles a strobe is held high (≥1)
- `POLL_GAP`, default 4, idle cycles between status polls
- `POLL_LIMIT`, default 255, max status polls before timeout (≥1)

Ports (one clock `clk`; reset `n_reset` is asynchronous, active-low):
- `clk` input 1: single clock
- `n_reset` input 1: async active-low reset
- `start` input 1: job request, sampled only in IDLE
- `arg_a` input 24: operand A, captured when `start` is accepted
- `arg_b` input 24: operand B, captured when `start` is accepted
- `busy` output 1: high from the cycle after acceptance through the DONE cycle
- `done` output 1: one-cycle pulse at job end
- `err_timeout` output 1: valid with `done`; 1 = poll limit reached
- `result_w` output 32: product read from `ADDR_W`, held until next `done`
- `result_l` output 24: ones-count, `sdata_rd[23:0]` from `ADDR_L`, held
- `saddress` output 16: bus address
- `srd` output 1: read strobe
- `swr` output 1: write strobe
- `sdata_wr` output 32: write data to peripheral
- `sdata_rd` input 32: read data from peripheral

## Operation
- Bus access (A = STROBE_CYCLES+2 cycles):
  - SETUP, 1 cycle: drive address and data, strobes low.
  - STROBE, STROBE_CYCLES cycles: strobe high, address and data stable.
  - HOLD, 1 cycle: strobe low, address and data still stable.
  - Reads sample `sdata_rd` on the last STROBE cycle.
  - `srd` and `swr` are never high together.
- FSM: IDLE → WR_A1 → WR_A2 → WR_CTRL → POLL → (GAP → POLL)* → RD_W → RD_L → DONE → IDLE.
- Write data:
  - WR_A1 writes `{8'h0,arg_a}`.
  - WR_A2 writes `{8'h0,arg_b}`.
  - WR_CTRL writes 32'h0; the address itself triggers the job.
- POLL reads `ADDR_CTRL`:
  - `sdata_rd[1:0]==2'b11` → RD_W.
  - Any other value → GAP (POLL_GAP cycles, bus idle) → POLL.
  - The first POLL starts immediately after the WR_CTRL HOLD cycle.
- Timeout: the POLL_LIMIT-th poll fails → DONE with `err_timeout`=1. `result_w`/`result_l` are set to 0 and the read-back phases are skipped.
- DONE: 1 cycle, `done`=1, `busy`=1; `start` is ignored. The next cycle is IDLE.
- `start` is ignored while busy and has no queueing. Operands are frozen at acceptance.
- Idle bus state: `saddress`=0, `sdata_wr`=0, strobes low.

## Timing
- Reset values: `busy`=0, `done`=0, `err_timeout`=0, `result_w`=0, `result_l`=0, `saddress`=0, `srd`=0, `swr`=0, `sdata_wr`=0, FSM=IDLE.
- Reset mid-operation: all outputs take their reset values immediately, asynchronously, including dropping an active strobe. Captured operands and the poll counter are cleared.
- Acceptance: `start` high at a clk edge in IDLE → WR_A1 SETUP in the next cycle; `busy` rises in that same cycle.
- Latency from acceptance to `done` with P polls (success): 5A + P·A + (P−1)·POLL_GAP + 1 cycles. With defaults and P=1 this is 25 cycles.
- `result_w`, `result_l` and `err_timeout` update in the DONE cycle and are stable until the next DONE.

## Structure
- Package `mulcnt_host_pkg`:
  - default address constants
  - FSM state enum
  - `STAT_DONE`=2'b11
  - bus phase enum (SETUP/STROBE/HOLD)
- Sub-module `sbus_access`: executes one read or write access.
  - Inputs: req, rnw, addr, wdata.
  - Outputs: ack (1-cycle, in HOLD), rdata, and the bus pins.
  - The top FSM only sequences accesses.

## Test plan
- Responder model returns status 2'b11 on the first poll, W=32'h0000000F, L=4. Pulse `start` with a=3, b=5 → the bench observes writes {0x380:3, 0x388:5, 0x3A0:0}, 1 poll, reads 0x390 and 0x398; `done` arrives 25 cycles after acceptance; `result_w`=0xF, `result_l`=4, `err_timeout`=0.
- Status returns 2'b01 for 3 polls, then 2'b11 → 4 polls, with gaps of exactly POLL_GAP idle cycles; latency 5A+4A+3·4+1=49.
- Status is never 2'b11, POLL_LIMIT=3 → exactly 3 polls, no reads of 0x390/0x398, `done` with `err_timeout`=1 and results 0.
- `start` re-pulsed while busy, and during the DONE cycle → ignored; exactly one job runs on the bus.
- `n_reset` asserted during the STROBE of WR_A2 → `swr` drops asynchronously and all outputs reset. A fresh `start` after release runs a full job.
- Strobe checker over all tests:
  - `srd` and `swr` never high together.
  - Each strobe lasts exactly STROBE_CYCLES cycles.
  - Address is stable from SETUP through HOLD.
